// File: rtl/accel_spi_responder.sv
// accel_spi_responder
//    SPI mode-3 slave emulating an ADXL345-style register interface, so the
//    FIR path's SPI master can be fed from a deterministic sample source.
//
//    Ports
//       sys_clk, reset_n        system clock, async active-low reset
//       spi_sclk/cs/mosi        SPI pins from the master (async to sys_clk)
//       spi_miso, spi_miso_oe   slave data out and its tristate enable
//       x/y/z_sample            16-bit two's-complement samples
//       sample_valid            one-cycle strobe qualifying the samples
//       int1                    DATA_READY interrupt (registered)
//       busy                    synchronised chip select is low
//
//    Frame FSM
//       state    | meaning
//       ST_IDLE  | cs high (or not yet armed), waiting for a cs falling edge
//       ST_CMD   | shifting in the command byte {R/W, MB, A[5:0]}
//       ST_DATA  | data bytes: writes commit / reads reload per byte
module accel_spi_responder #(
   parameter logic [7:0] DEVID       = 8'hE5,
   parameter int         SYNC_STAGES = 2
) (
   input  logic        sys_clk,
   input  logic        reset_n,
   input  logic        spi_sclk,
   input  logic        spi_cs,
   input  logic        spi_mosi,
   output logic        spi_miso,
   output logic        spi_miso_oe,
   input  logic [15:0] x_sample,
   input  logic [15:0] y_sample,
   input  logic [15:0] z_sample,
   input  logic        sample_valid,
   output logic        int1,
   output logic        busy
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CMD  = 2'd1,
      ST_DATA = 2'd2
   } state_t;

   logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
   logic       sclk_d, cs_d;
   logic       sclk_s, cs_s, mosi_s;
   logic       sclk_rise, sclk_fall, cs_rise, cs_fall;
   logic       rst_seen, armed;

   state_t     state;
   logic [2:0] bit_cnt;
   logic [7:0] shift_in, shift_out;
   logic [5:0] addr;
   logic       rw, mb, load_req;
   logic [7:0] rx_byte;
   logic       byte_done, wr_en, rd_done_37;

   logic [7:0]  bw_rate, power_ctl, int_enable, data_format;
   logic [15:0] data_x, data_y, data_z;
   logic [15:0] pend_x, pend_y, pend_z;
   logic        pend_valid, data_ready;
   logic [7:0]  rd_data;

   // sclk and cs reset to their idle (high) level so reset produces no edges.
   always_ff @(posedge sys_clk or negedge reset_n) begin
      if (!reset_n) begin
         sclk_sync <= '1;
         cs_sync   <= '1;
         mosi_sync <= '0;
         sclk_d    <= 1'b1;
         cs_d      <= 1'b1;
         rst_seen  <= 1'b0;
         armed     <= 1'b0;
      end else begin
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
         cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
         sclk_d    <= sclk_s;
         cs_d      <= cs_s;
         rst_seen  <= 1'b1;
         // A frame may only start after cs has really been seen high since
         // reset; a reset in the middle of a frame must not restart it.
         if (rst_seen && cs_sync[0])
            armed <= 1'b1;
      end
   end

   assign sclk_s    = sclk_sync[SYNC_STAGES-1];
   assign cs_s      = cs_sync[SYNC_STAGES-1];
   assign mosi_s    = mosi_sync[SYNC_STAGES-1];
   assign sclk_rise = sclk_s & ~sclk_d;
   assign sclk_fall = ~sclk_s & sclk_d;
   assign cs_rise   = cs_s & ~cs_d;
   assign cs_fall   = ~cs_s & cs_d;
   assign busy      = ~cs_s;

   assign rx_byte    = {shift_in[6:0], mosi_s};
   assign byte_done  = (state != ST_IDLE) && !cs_rise && sclk_rise && (bit_cnt == 3'd7);
   assign wr_en      = byte_done && (state == ST_DATA) && !rw;
   assign rd_done_37 = byte_done && (state == ST_DATA) && rw && (addr == 6'h37);

   always_comb begin
      rd_data = 8'h00;
      case (addr)
         6'h00:   rd_data = DEVID;
         6'h2C:   rd_data = bw_rate;
         6'h2D:   rd_data = power_ctl;
         6'h2E:   rd_data = int_enable;
         6'h30:   rd_data = {data_ready, 7'b0};
         6'h31:   rd_data = data_format;
         6'h32:   rd_data = data_x[7:0];
         6'h33:   rd_data = data_x[15:8];
         6'h34:   rd_data = data_y[7:0];
         6'h35:   rd_data = data_y[15:8];
         6'h36:   rd_data = data_z[7:0];
         6'h37:   rd_data = data_z[15:8];
         default: rd_data = 8'h00;
      endcase
   end

   always_ff @(posedge sys_clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= ST_IDLE;
         bit_cnt     <= 3'd0;
         shift_in    <= 8'h00;
         shift_out   <= 8'h00;
         addr        <= 6'h00;
         rw          <= 1'b0;
         mb          <= 1'b0;
         load_req    <= 1'b0;
         spi_miso    <= 1'b0;
         spi_miso_oe <= 1'b0;
      end else if (cs_rise) begin
         // Partial bytes are simply dropped; nothing was written for them.
         state       <= ST_IDLE;
         bit_cnt     <= 3'd0;
         load_req    <= 1'b0;
         spi_miso_oe <= 1'b0;
      end else if (cs_fall && armed) begin
         state    <= ST_CMD;
         bit_cnt  <= 3'd0;
         shift_in <= 8'h00;
         load_req <= 1'b0;
      end else if (state != ST_IDLE) begin
         if (sclk_rise) begin
            shift_in <= rx_byte;
            bit_cnt  <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
               if (state == ST_CMD) begin
                  rw       <= rx_byte[7];
                  mb       <= rx_byte[6];
                  addr     <= rx_byte[5:0];
                  load_req <= rx_byte[7];
                  state    <= ST_DATA;
               end else begin
                  if (mb)
                     addr <= addr + 6'd1;
                  load_req <= rw;
               end
            end
         end else if (sclk_fall) begin
            if (load_req) begin
               // Snapshot the whole byte now so later register updates
               // cannot corrupt a byte already in flight.
               spi_miso    <= rd_data[7];
               shift_out   <= {rd_data[6:0], 1'b0};
               spi_miso_oe <= 1'b1;
               load_req    <= 1'b0;
            end else if (spi_miso_oe) begin
               spi_miso  <= shift_out[7];
               shift_out <= {shift_out[6:0], 1'b0};
            end
         end
      end
   end

   always_ff @(posedge sys_clk or negedge reset_n) begin
      if (!reset_n) begin
         bw_rate     <= 8'h0A;
         power_ctl   <= 8'h00;
         int_enable  <= 8'h00;
         data_format <= 8'h00;
         data_x      <= 16'h0000;
         data_y      <= 16'h0000;
         data_z      <= 16'h0000;
         pend_x      <= 16'h0000;
         pend_y      <= 16'h0000;
         pend_z      <= 16'h0000;
         pend_valid  <= 1'b0;
         data_ready  <= 1'b0;
         int1        <= 1'b0;
      end else begin
         if (wr_en) begin
            case (addr)
               6'h2C:   bw_rate     <= rx_byte;
               6'h2D:   power_ctl   <= rx_byte;
               6'h2E:   int_enable  <= rx_byte;
               6'h31:   data_format <= rx_byte;
               default: ;
            endcase
         end
         if (rd_done_37)
            data_ready <= 1'b0;
         // Later assignments win: commit/set override a same-cycle clear.
         if (cs_rise && pend_valid) begin
            data_x     <= pend_x;
            data_y     <= pend_y;
            data_z     <= pend_z;
            data_ready <= 1'b1;
            pend_valid <= 1'b0;
         end
         if (sample_valid && power_ctl[3]) begin
            if (cs_s) begin
               data_x     <= x_sample;
               data_y     <= y_sample;
               data_z     <= z_sample;
               data_ready <= 1'b1;
            end else begin
               pend_x     <= x_sample;
               pend_y     <= y_sample;
               pend_z     <= z_sample;
               pend_valid <= 1'b1;
            end
         end
         int1 <= data_ready & int_enable[7];
      end
   end

endmodule

// File: tb/tb_accel_spi_responder.sv
module tb_accel_spi_responder;

   logic        sys_clk = 1'b0;
   logic        reset_n;
   logic        spi_sclk, spi_cs, spi_mosi;
   logic        spi_miso, spi_miso_oe;
   logic [15:0] x_sample, y_sample, z_sample;
   logic        sample_valid;
   logic        int1, busy;

   int checks = 0;
   int errors = 0;

   logic [7:0] rx_buf [0:7];

   typedef struct {
      string       name;
      logic [7:0]  cmd;
      int          nbytes;
      logic [47:0] tx;
      logic [47:0] exp;
      bit          rd;
   } vec_t;

   vec_t vecs [10];

   accel_spi_responder #(.DEVID(8'hE5), .SYNC_STAGES(2)) dut (
      .sys_clk      (sys_clk),
      .reset_n      (reset_n),
      .spi_sclk     (spi_sclk),
      .spi_cs       (spi_cs),
      .spi_mosi     (spi_mosi),
      .spi_miso     (spi_miso),
      .spi_miso_oe  (spi_miso_oe),
      .x_sample     (x_sample),
      .y_sample     (y_sample),
      .z_sample     (z_sample),
      .sample_valid (sample_valid),
      .int1         (int1),
      .busy         (busy)
   );

   always #5 sys_clk = ~sys_clk;

   initial begin
      #2ms;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
      rx = 8'h00;
      for (int i = 0; i < n; i++) begin
         spi_sclk = 1'b0;
         spi_mosi = tx[7-i];
         repeat (6) @(negedge sys_clk);
         rx[7-i]  = spi_miso;
         spi_sclk = 1'b1;
         repeat (6) @(negedge sys_clk);
      end
   endtask

   task automatic cs_low();
      spi_cs = 1'b0;
      repeat (6) @(negedge sys_clk);
      check("busy_in_frame", {15'd0, busy}, 16'd1);
   endtask

   task automatic cs_high();
      repeat (4) @(negedge sys_clk);
      spi_cs = 1'b1;
      repeat (8) @(negedge sys_clk);
   endtask

   task automatic xfer(input logic [7:0] cmd, input int n, input logic [47:0] tx);
      logic [7:0] dummy;
      logic [7:0] r;
      cs_low();
      spi_bits(cmd, 8, dummy);
      for (int b = 0; b < n; b++) begin
         spi_bits(tx[47-8*b -: 8], 8, r);
         rx_buf[b] = r;
      end
      cs_high();
      check("oe_after_cs", {15'd0, spi_miso_oe}, 16'd0);
   endtask

   task automatic pulse_sample(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
      @(negedge sys_clk);
      x_sample     = x;
      y_sample     = y;
      z_sample     = z;
      sample_valid = 1'b1;
      @(negedge sys_clk);
      sample_valid = 1'b0;
   endtask

   initial begin
      logic [7:0]  r;
      logic [47:0] e;

      vecs[0] = '{"devid",        8'h80, 1, 48'h0,           48'hE5_0000000000, 1'b1};
      vecs[1] = '{"bw_rate",      8'hAC, 1, 48'h0,           48'h0A_0000000000, 1'b1};
      vecs[2] = '{"wr_int_en",    8'h2E, 1, 48'h80_00000000_00, 48'h0,         1'b0};
      vecs[3] = '{"wr_ro_src",    8'h30, 1, 48'hFF_0000000000, 48'h0,          1'b0};
      vecs[4] = '{"rd_int_src",   8'hB0, 1, 48'h0,           48'h00_0000000000, 1'b1};
      vecs[5] = '{"rd_data_m0",   8'hF2, 2, 48'h0,           48'h0000_00000000, 1'b1};
      vecs[6] = '{"mb_wrap",      8'hFF, 2, 48'h0,           48'h00E5_00000000, 1'b1};
      vecs[7] = '{"mb0_hold",     8'h80, 3, 48'h0,           48'hE5E5E5_000000, 1'b1};
      vecs[8] = '{"wr_power",     8'h2D, 1, 48'h08_0000000000, 48'h0,          1'b0};
      vecs[9] = '{"rd_ctl_mb",    8'hEC, 3, 48'h0,           48'h0A0880_000000, 1'b1};

      reset_n      = 1'b0;
      spi_sclk     = 1'b1;
      spi_cs       = 1'b1;
      spi_mosi     = 1'b0;
      x_sample     = 16'h0;
      y_sample     = 16'h0;
      z_sample     = 16'h0;
      sample_valid = 1'b0;

      repeat (3) @(negedge sys_clk);
      check("rst_miso", {15'd0, spi_miso},    16'd0);
      check("rst_oe",   {15'd0, spi_miso_oe}, 16'd0);
      check("rst_int1", {15'd0, int1},        16'd0);
      check("rst_busy", {15'd0, busy},        16'd0);
      reset_n = 1'b1;
      repeat (5) @(negedge sys_clk);

      // Sample while MEASURE=0 must be ignored.
      pulse_sample(16'hAAAA, 16'h5555, 16'h7777);

      for (int v = 0; v < 10; v++) begin
         xfer(vecs[v].cmd, vecs[v].nbytes, vecs[v].tx);
         if (vecs[v].rd)
            for (int b = 0; b < vecs[v].nbytes; b++)
               check($sformatf("%s_b%0d", vecs[v].name, b), {8'h00, rx_buf[b]},
                     {8'h00, vecs[v].exp[47-8*b -: 8]});
      end
      check("int1_meas0", {15'd0, int1}, 16'd0);

      // Capture with cs high: int1 two cycles after the strobe.
      @(negedge sys_clk);
      x_sample     = 16'h1234;
      y_sample     = 16'hFFFE;
      z_sample     = 16'h8000;
      sample_valid = 1'b1;
      @(negedge sys_clk);
      sample_valid = 1'b0;
      check("int1_lat1", {15'd0, int1}, 16'd0);
      @(negedge sys_clk);
      check("int1_lat2", {15'd0, int1}, 16'd1);

      xfer(8'hB0, 1, 48'h0);
      check("int_src_set", {8'h00, rx_buf[0]}, 16'h0080);

      e = 48'h3412_FEFF_0080;
      cs_low();
      spi_bits(8'hF2, 8, r);
      for (int b = 0; b < 6; b++) begin
         spi_bits(8'h00, 8, r);
         check($sformatf("burst1_b%0d", b), {8'h00, r}, {8'h00, e[47-8*b -: 8]});
         if (b == 4)
            check("int1_before_37", {15'd0, int1}, 16'd1);
      end
      check("int1_after_37", {15'd0, int1}, 16'd0);
      cs_high();

      // New sample mid-burst: in-flight bytes keep old data, commit on cs rise.
      cs_low();
      spi_bits(8'hF2, 8, r);
      spi_bits(8'h00, 8, r);
      check("burst2_b0", {8'h00, r}, 16'h0034);
      pulse_sample(16'h0001, 16'h0002, 16'h0003);
      for (int b = 1; b < 6; b++) begin
         spi_bits(8'h00, 8, r);
         check($sformatf("burst2_b%0d", b), {8'h00, r}, {8'h00, e[47-8*b -: 8]});
      end
      check("int1_pend_held", {15'd0, int1}, 16'd0);
      cs_high();
      check("int1_commit", {15'd0, int1}, 16'd1);
      xfer(8'hB0, 1, 48'h0);
      check("int_src_commit", {8'h00, rx_buf[0]}, 16'h0080);
      e = 48'h0100_0200_0300;
      xfer(8'hF2, 6, 48'h0);
      for (int b = 0; b < 6; b++)
         check($sformatf("burst3_b%0d", b), {8'h00, rx_buf[b]}, {8'h00, e[47-8*b -: 8]});

      // Aborted write: cs rises after 5 data bits.
      cs_low();
      spi_bits(8'h31, 8, r);
      spi_bits(8'hFF, 5, r);
      cs_high();
      xfer(8'hB1, 1, 48'h0);
      check("abort_fmt", {8'h00, rx_buf[0]}, 16'h0000);
      xfer(8'h31, 1, 48'h0B_0000000000);
      xfer(8'hB1, 1, 48'h0);
      check("wr_fmt", {8'h00, rx_buf[0]}, 16'h000B);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
